boundary_scan_ctrl: RTL and testbench
=====================================

# boundary_scan_ctrl

Frame-scan sequencer for the digit boundary-detection datapath. Accepts the binarised pixel stream and generates the per-pixel column address, row address, black/white run lengths and write enable. Sequences one frame per `start`, clears the left/right boundary trackers at frame start, and captures their final min/max results once the pipeline has settled. Sits between the binarisation stage and the left/right boundary block, and hands finished edges to the recognition stage.

## Interface
Parameters:
- `H_ACT`, 320: active pixels per row; must be 2..512.
- `V_ACT`, 240: active rows per frame; must be 1..512.
- `ROI_X0`, 0 / `ROI_X1`, 319: inclusive column window for `wren`.
- `ROI_Y0`, 0 / `ROI_Y1`, 239: inclusive row window for `wren`.
- `SETTLE`, 2: cycles to wait after the last pixel before capturing results; must be 1..15.

Ports:
- `clock` in 1: single clock for the whole block.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle frame request; ignored unless state is IDLE.
- `pix_valid` in 1: pixel strobe.
- `pix_black` in 1: 1 = black pixel; sampled only with `pix_valid`.
- `sof` in 1: first pixel of a frame; sampled only with `pix_valid`.
- `hcount` out 9: column of the last accepted pixel.
- `vcount` out 9: row of the last accepted pixel.
- `sum_black` out 9: current consecutive-black run length in the row.
- `sum_white` out 9: current consecutive-white run length in the row.
- `wren` out 1: last accepted pixel lies inside the ROI.
- `clr_dp` out 1: one-cycle clear to the boundary trackers.
- `left_in` in 9 / `right_in` in 9: running min-left / max-right from the trackers.
- `left_edge` out 9 / `right_edge` out 9: captured frame result.
- `found` out 1: captured `left_in <= right_in`, i.e. at least one edge was seen.
- `result_valid` out 1: one-cycle pulse when the edges are updated.
- `busy` out 1: state is not IDLE.
- `frame_err` out 1: sticky; set on an early `sof`, cleared on an accepted `start`.

## Operation
- **States:** IDLE, WAIT_SOF, SCAN, SETTLE.
- **IDLE → WAIT_SOF:** on `start`.
- **WAIT_SOF:** pixels without `sof` are dropped, producing no output change. A pixel with `pix_valid && sof` is accepted as (0,0), pulses `clr_dp`, and moves to SCAN.
- **SCAN, per accepted pixel:**
  - x advances by 1. At x = H_ACT-1 it wraps to 0 and y advances by 1.
  - Run counters are reset at x = 0:
    - a black pixel gives sum_black = 1 (x = 0) or sum_black + 1 saturating at 511, and sets sum_white = 0.
    - a white pixel is symmetric.
- **SCAN → SETTLE:** on acceptance of pixel (H_ACT-1, V_ACT-1); the SETTLE counter loads 0.
- **Early `sof` in SCAN** (not at the last pixel): set `frame_err`, pulse `clr_dp`, restart at (0,0) with that pixel. Remain in SCAN.
- **SETTLE:** the counter increments every cycle. When it reaches SETTLE-1:
  - latch `left_in` → `left_edge` and `right_in` → `right_edge`;
  - latch `found`;
  - pulse `result_valid`;
  - go to IDLE.
- **Inputs outside SCAN/WAIT_SOF:** `pix_valid` in SETTLE or IDLE is ignored.
- **`start` while busy:** ignored; it does not clear `frame_err`.
- **Reset (any time, including mid-frame):** state IDLE; all outputs 0, including `left_edge`, `right_edge`, `found` and `frame_err`; SETTLE counter 0.

## Timing
- All outputs are registered.
- A pixel accepted in cycle N produces `hcount`, `vcount`, `sum_black`, `sum_white` and `wren` in cycle N+1.
- `wren` is 0 in any cycle following one with no accepted pixel.
- `clr_dp` is high in cycle N+1 for an `sof` pixel accepted in cycle N, coincident with that pixel's `wren`. Trackers must treat clear as taking priority over the write.
- Last pixel accepted in cycle N:
  - its `wren` appears in N+1;
  - `result_valid`, the new edges and `busy` = 0 appear in N+1+SETTLE.
- Back-to-back frames: `start` is accepted in the same cycle `busy` drops.
- `pix_valid` may be high every cycle; there is no backpressure.

## Test plan
- **Single frame, ROI enabled.** H_ACT=16, V_ACT=4, full ROI. Pulse `start`, then 64 continuous pixels with `sof` on the first.
  - `hcount` 0..15 repeating and `vcount` 0..3.
  - `wren` high for 64 cycles.
  - `result_valid` 1+SETTLE cycles after the last pixel.
- **Run lengths.** Row pattern: 12 black, 4 white.
  - `sum_black` 1..12 then 0; `sum_white` 0 then 1..4.
  - Counters restart at 1 on the next row's x = 0.
- **ROI gating.** ROI_X0=4, ROI_X1=7, ROI_Y0=1, ROI_Y1=2 → `wren` high only for x 4..7 on rows 1..2, 8 pulses total.
- **Edge capture.** Drive `left_in`=3 and `right_in`=11 → `left_edge`=3, `right_edge`=11, `found`=1. Then `left_in`=511, `right_in`=0 → `found`=0.
- **Early `sof`.** `sof` at pixel 20 mid-frame:
  - `frame_err`=1 and `clr_dp` pulse;
  - counters restart at (0,0);
  - frame then completes 64 pixels later;
  - the next `start` clears `frame_err`.
- **Reset mid-SCAN.** Assert `rst` mid-SCAN → all outputs 0 immediately. `sof` pixels before a new `start` are ignored.

Source files
------------

// File: rtl/boundary_scan_ctrl.sv
// boundary_scan_ctrl: frame-scan sequencer producing pixel coordinates, run lengths,
// ROI write enable and settled left/right boundary capture.
module boundary_scan_ctrl #(
  parameter int H_ACT  = 320,
  parameter int V_ACT  = 240,
  parameter int ROI_X0 = 0,
  parameter int ROI_X1 = 319,
  parameter int ROI_Y0 = 0,
  parameter int ROI_Y1 = 239,
  parameter int SETTLE = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic       pix_valid,
  input  logic       pix_black,
  input  logic       sof,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic [8:0] sum_black,
  output logic [8:0] sum_white,
  output logic       wren,
  output logic       clr_dp,
  input  logic [8:0] left_in,
  input  logic [8:0] right_in,
  output logic [8:0] left_edge,
  output logic [8:0] right_edge,
  output logic       found,
  output logic       result_valid,
  output logic       busy,
  output logic       frame_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_SETTLE} state_t;
  localparam logic [8:0] XL = 9'(H_ACT - 1);
  localparam logic [8:0] YL = 9'(V_ACT - 1);
  localparam logic [3:0] SL = 4'(SETTLE - 1);
  state_t state_q, state_d;
  logic [8:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [8:0] sum_black_q, sum_black_d, sum_white_q, sum_white_d;
  logic [8:0] left_edge_q, left_edge_d, right_edge_q, right_edge_d;
  logic [3:0] cnt_q, cnt_d;
  logic wren_q, wren_d, clr_dp_q, clr_dp_d, found_q, found_d;
  logic result_valid_q, result_valid_d, busy_q, busy_d, frame_err_q, frame_err_d;
  logic accept, restart, last, done;
  logic [8:0] nx, ny;
  assign accept  = pix_valid && ((state_q == S_WAIT && sof) || state_q == S_SCAN);
  assign restart = accept && sof;
  assign nx      = (restart || hcount_q == XL) ? '0 : hcount_q + 9'd1;
  assign ny      = restart ? '0 : hcount_q == XL ? vcount_q + 9'd1 : vcount_q;
  assign last    = accept && !sof && nx == XL && ny == YL;
  assign done    = state_q == S_SETTLE && cnt_q == SL;
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WAIT;
      S_WAIT:  if (restart) state_d = S_SCAN;
      S_SCAN:  if (last) state_d = S_SETTLE;
      default: if (done) state_d = S_IDLE;
    endcase
  end
  // Run counters restart on every x = 0 so each row is measured independently.
  always_comb begin
    hcount_d       = accept ? nx : hcount_q;
    vcount_d       = accept ? ny : vcount_q;
    sum_black_d    = !accept ? sum_black_q : !pix_black ? '0 : nx == '0 ? 9'd1 :
                     sum_black_q == 9'd511 ? sum_black_q : sum_black_q + 9'd1;
    sum_white_d    = !accept ? sum_white_q : pix_black ? '0 : nx == '0 ? 9'd1 :
                     sum_white_q == 9'd511 ? sum_white_q : sum_white_q + 9'd1;
    wren_d         = accept && int'(nx) >= ROI_X0 && int'(nx) <= ROI_X1 &&
                     int'(ny) >= ROI_Y0 && int'(ny) <= ROI_Y1;
    clr_dp_d       = restart;
    cnt_d          = (last || done) ? '0 : state_q == S_SETTLE ? cnt_q + 4'd1 : cnt_q;
    left_edge_d    = done ? left_in : left_edge_q;
    right_edge_d   = done ? right_in : right_edge_q;
    found_d        = done ? left_in <= right_in : found_q;
    result_valid_d = done;
    busy_d         = state_d != S_IDLE;
    frame_err_d    = (restart && state_q == S_SCAN) || (frame_err_q && !(state_q == S_IDLE && start));
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hcount_q       <= '0;
      vcount_q       <= '0;
      sum_black_q    <= '0;
      sum_white_q    <= '0;
      wren_q         <= 1'b0;
      clr_dp_q       <= 1'b0;
      cnt_q          <= '0;
      left_edge_q    <= '0;
      right_edge_q   <= '0;
      found_q        <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      sum_black_q    <= sum_black_d;
      sum_white_q    <= sum_white_d;
      wren_q         <= wren_d;
      clr_dp_q       <= clr_dp_d;
      cnt_q          <= cnt_d;
      left_edge_q    <= left_edge_d;
      right_edge_q   <= right_edge_d;
      found_q        <= found_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      frame_err_q    <= frame_err_d;
    end
  end
  assign hcount       = hcount_q;
  assign vcount       = vcount_q;
  assign sum_black    = sum_black_q;
  assign sum_white    = sum_white_q;
  assign wren         = wren_q;
  assign clr_dp       = clr_dp_q;
  assign left_edge    = left_edge_q;
  assign right_edge   = right_edge_q;
  assign found        = found_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;
endmodule

// File: tb/tb_boundary_scan_ctrl.sv
// tb_boundary_scan_ctrl: randomized frames on a 16x4 raster checked against a
// pixel-index reference model; a second instance covers ROI gating.
module tb_boundary_scan_ctrl;
  localparam int SETTLE = 2;
  logic clk = 1'b0, rst, start, pix_valid, pix_black, sof;
  logic [8:0] left_in, right_in;
  logic [8:0] hcount, vcount, sum_black, sum_white, left_edge, right_edge;
  logic wren, clr_dp, found, result_valid, busy, frame_err;
  logic [8:0] r_hcount, r_vcount, r_sb, r_sw, r_le, r_re;
  logic r_wren, r_clr, r_found, r_rv, r_busy, r_err;
  int n_chk = 0, n_fail = 0;
  int ph, idx, wait_n;
  int e_h, e_v, e_sb, e_sw, e_wren, e_wroi, e_clr, e_rv, e_le, e_re, e_found, e_err, e_busy;
  bit rowc [16];

  always #5 clk = ~clk;

  boundary_scan_ctrl #(.H_ACT(16), .V_ACT(4), .ROI_X0(0), .ROI_X1(15), .ROI_Y0(0), .ROI_Y1(3),
    .SETTLE(SETTLE)) dut (
    .clock(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_black(pix_black),
    .sof(sof), .hcount(hcount), .vcount(vcount), .sum_black(sum_black), .sum_white(sum_white),
    .wren(wren), .clr_dp(clr_dp), .left_in(left_in), .right_in(right_in),
    .left_edge(left_edge), .right_edge(right_edge), .found(found),
    .result_valid(result_valid), .busy(busy), .frame_err(frame_err));

  boundary_scan_ctrl #(.H_ACT(16), .V_ACT(4), .ROI_X0(4), .ROI_X1(7), .ROI_Y0(1), .ROI_Y1(2),
    .SETTLE(SETTLE)) dut_roi (
    .clock(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_black(pix_black),
    .sof(sof), .hcount(r_hcount), .vcount(r_vcount), .sum_black(r_sb), .sum_white(r_sw),
    .wren(r_wren), .clr_dp(r_clr), .left_in(left_in), .right_in(right_in),
    .left_edge(r_le), .right_edge(r_re), .found(r_found),
    .result_valid(r_rv), .busy(r_busy), .frame_err(r_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; idx = 0; wait_n = 0;
    e_h = 0; e_v = 0; e_sb = 0; e_sw = 0; e_wren = 0; e_wroi = 0; e_clr = 0;
    e_rv = 0; e_le = 0; e_re = 0; e_found = 0; e_err = 0; e_busy = 0;
  endtask

  // Phases: 0 idle, 1 waiting for sof, 2 scanning, 3 settling.
  task automatic model(input bit pv, input bit blk, input bit s, input bit st);
    bit acc;
    int x, y, run;
    e_wren = 0; e_wroi = 0; e_clr = 0; e_rv = 0;
    acc = pv && ((ph == 1 && s) || ph == 2);
    if (ph == 0 && st) begin
      ph = 1; e_err = 0;
    end else if (ph == 3) begin
      wait_n--;
      if (wait_n == 0) begin
        e_le = int'(left_in); e_re = int'(right_in);
        e_found = (left_in <= right_in) ? 1 : 0; e_rv = 1; ph = 0;
      end
    end
    if (acc) begin
      if (s) begin
        if (ph == 2) e_err = 1;
        idx = 0; e_clr = 1; ph = 2;
      end else idx++;
      x = idx % 16; y = idx / 16; rowc[x] = blk; run = 0;
      for (int k = x; k >= 0 && rowc[k] == blk; k--) run++;
      e_h = x; e_v = y;
      e_sb = blk ? run : 0; e_sw = blk ? 0 : run;
      e_wren = 1;
      e_wroi = (x >= 4 && x <= 7 && y >= 1 && y <= 2) ? 1 : 0;
      if (!s && idx == 63) begin ph = 3; wait_n = SETTLE; end
    end
    e_busy = (ph != 0) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("hcount", hcount, e_h);
    chk("vcount", vcount, e_v);
    chk("sum_black", sum_black, e_sb);
    chk("sum_white", sum_white, e_sw);
    chk("wren", wren, e_wren);
    chk("wren_roi", r_wren, e_wroi);
    chk("clr_dp", clr_dp, e_clr);
    chk("result_valid", result_valid, e_rv);
    chk("busy", busy, e_busy);
    chk("frame_err", frame_err, e_err);
    chk("left_edge", left_edge, e_le);
    chk("right_edge", right_edge, e_re);
    chk("found", found, e_found);
  endtask

  task automatic step(input bit pv, input bit blk, input bit s, input bit st);
    pix_valid = pv; pix_black = blk; sof = s; start = st;
    @(posedge clk);
    model(pv, blk, s, st);
    #1;
    check_all();
  endtask

  task automatic frame(input int pct, input int early, input bit pat, input bit rnd_edges);
    int budget, nx;
    bit used, pv, s, blk;
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    used = 0; budget = 0;
    while (ph != 0 && budget < 1000) begin
      budget++;
      pv = $urandom_range(99) < pct;
      s = pv && (ph == 1 || (early > 0 && !used && ph == 2 && idx == early - 1));
      if (s && ph == 2) used = 1;
      nx = s ? 0 : (idx + 1) % 16;
      blk = pat ? (nx < 12) : ($urandom_range(1) == 1);
      if (rnd_edges) begin
        left_in = 9'($urandom_range(511)); right_in = 9'($urandom_range(511));
      end
      step(pv, blk, s, $urandom_range(19) == 0);
    end
    chk("frame_done_in_budget", (budget < 1000) ? 1 : 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 0; pix_valid = 0; pix_black = 0; sof = 0;
    left_in = 0; right_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    left_in = 9'd3; right_in = 9'd11;
    frame(100, 0, 1, 0);
    chk("edge_found", found, 1);
    left_in = 9'd511; right_in = 9'd0;
    frame(100, 0, 0, 0);
    chk("edge_notfound", found, 0);
    frame(80, 20, 1, 0);
    chk("err_after_early", frame_err, 1);
    frame(100, 0, 0, 1);
    chk("err_cleared", frame_err, 0);
    repeat (6) frame(70, ($urandom_range(1) == 1) ? int'($urandom_range(50, 5)) : 0,
                     $urandom_range(1) == 1, 1);
    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    repeat (30) step(1, $urandom_range(1) == 1, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(1, 1, 1, 0);
    frame(90, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
